mini_ctrl_seq: RTL and testbench
================================

// Module: mini_ctrl_seq
// PURPOSE
//  Multi-cycle control sequencer for the mini processor datapath. Fetches 16-bit
//  instructions over a req/ack memory handshake, decodes them, and drives regfile
//  read addresses, ALU op, immediate and a one-cycle write enable. Owns the PC.
//  Sits between instruction memory and the 4x8-bit regfile/ALU datapath.
// PARAMETERS
//  PC_W     8   program counter / imem address width
//  INSTR_W  16  instruction width (field positions below fixed for 16)
//  CNT_W    16  retired-instruction counter width
// PORTS
//  clk         in   1        rising-edge clock
//  rst         in   1        synchronous, active-high reset
//  start       in   1        pulse: begin execution at PC=0 (honoured in IDLE/HALT only)
//  imem_req    out  1        fetch request, held until imem_ack
//  imem_addr   out  PC_W     fetch address (= pc), stable while imem_req=1
//  imem_ack    in   1        memory accepts and returns imem_rdata this cycle
//  imem_rdata  in   INSTR_W  instruction, valid only when imem_ack=1
//  rf_raddr1   out  2        source 1 = instr[13:12]
//  rf_raddr2   out  2        source 2 = instr[11:10]
//  rf_waddr    out  2        dest = instr[15:14]
//  rf_we       out  1        regfile write strobe, one cycle in WB
//  alu_op      out  2        00 add, 01 sub, 10 pass {4'b0,imm}, 11 none
//  imm         out  4        instr[3:0]
//  busy        out  1        1 in FETCH/DECODE/EXEC/WB
//  halted      out  1        1 in HALT
//  instr_cnt   out  CNT_W    retired instructions since last start, saturating
// BEHAVIOUR
//  Reset: state=IDLE, pc=0, instr reg=0, instr_cnt=0; all outputs 0.
//  States: IDLE -start-> FETCH; FETCH -imem_ack-> DECODE; DECODE -> EXEC;
//   EXEC -> WB, or -> HALT if opcode instr[9:8]=11 and instr[7:4]=4'hF;
//   WB -> FETCH; HALT -start-> FETCH.
//  start in IDLE/HALT: pc<=0, instr_cnt<=0. start while busy: ignored.
//  FETCH: imem_req=1, imem_addr=pc; on imem_ack latch imem_rdata into instr reg.
//   imem_ack outside FETCH is ignored; imem_rdata never sampled without ack.
//  rf_raddr*/rf_waddr/alu_op/imm driven from instr reg in DECODE, EXEC, WB;
//   0 in other states.
//  WB: rf_we=1 for opcodes 00/01/10; rf_we=0 for 11 (nop). pc<=pc+1 (mod 2^PC_W,
//   255 wraps to 0). instr_cnt<=instr_cnt+1, holds at all-ones.
//  HALT instruction retires: instr_cnt increments on EXEC->HALT, pc not advanced,
//   no rf_we.
//  Latency: 4 cycles/instruction with imem_ack in first FETCH cycle; +1 per wait.
//  Reset mid-operation (any state, incl. FETCH with req pending): next edge IDLE,
//   imem_req=0, no rf_we issued for the interrupted instruction.
//  rf_we is registered-state-decoded: never asserted two consecutive cycles.
// STRUCTURE
//  Shared package mini_pkg: opcode constants OP_ADD/OP_SUB/OP_LDI/OP_NOP, alu_op
//   encodings, state enum, instruction field bit positions, HALT_TAG=4'hF.
//  One sub-module: mini_instr_decode (combinational: instr -> addrs, alu_op, imm,
//   writes_rf, is_halt). FSM, pc and counter stay in mini_ctrl_seq.
// TESTING
//  Reset then start, imem acks immediately with 16'h4400 (R1<=R0+R1) -> req 1 cycle,
//   rf_we=1 exactly 3 cycles after ack, rf_waddr=1, alu_op=00, pc 0->1.
//  Fetch with imem_ack delayed 3 cycles -> imem_req/imem_addr held stable, no
//   decode outputs, instruction period = 7 cycles.
//  Stream LDI 16'h8205 (R2<=5), NOP 16'h0300, HALT 16'h03F0 -> imm=5/alu_op=10
//   with rf_we; nop no rf_we; halted=1, pc=2, instr_cnt=3, busy=0.
//  pc wrap: 256 NOPs from start -> imem_addr sequence 0..255 then 0, no errors.
//  rst asserted during FETCH and during WB -> next cycle IDLE, imem_req=0, rf_we=0;
//   start while busy -> no effect on pc/instr_cnt.
//  Restart from HALT with start -> pc=0, instr_cnt=0, fetch resumes at addr 0.

Source files
------------

// File: rtl/mini_pkg.sv
// mini_pkg: shared opcodes, ALU encodings, FSM states and instruction field positions
package mini_pkg;
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_LDI = 2'b10;
    localparam logic [1:0] OP_NOP = 2'b11;
    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_PASS = 2'b10;
    localparam logic [1:0] ALU_NONE = 2'b11;
    localparam int RD_HI  = 15;
    localparam int RS1_HI = 13;
    localparam int RS2_HI = 11;
    localparam int OP_HI  = 9;
    localparam int TAG_HI = 7;
    localparam int IMM_HI = 3;
    localparam logic [3:0] HALT_TAG = 4'hF;
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT} state_t;
endpackage

// File: rtl/mini_instr_decode.sv
// mini_instr_decode: splits a 16-bit instruction into regfile addresses, ALU op and flags
module mini_instr_decode
    import mini_pkg::*;
(
    input  logic [15:0] instr,
    output logic [1:0]  raddr1,
    output logic [1:0]  raddr2,
    output logic [1:0]  waddr,
    output logic [1:0]  alu_op,
    output logic [3:0]  imm,
    output logic        writes_rf,
    output logic        is_halt
);
    logic [1:0] op;
    assign op        = instr[OP_HI -: 2];
    assign raddr1    = instr[RS1_HI -: 2];
    assign raddr2    = instr[RS2_HI -: 2];
    assign waddr     = instr[RD_HI -: 2];
    assign imm       = instr[IMM_HI -: 4];
    assign alu_op    = op == OP_ADD ? ALU_ADD : op == OP_SUB ? ALU_SUB : op == OP_LDI ? ALU_PASS : ALU_NONE;
    assign writes_rf = op != OP_NOP;
    assign is_halt   = op == OP_NOP && instr[TAG_HI -: 4] == HALT_TAG;
endmodule

// File: rtl/mini_ctrl_seq.sv
// mini_ctrl_seq: multi-cycle fetch/decode/exec/writeback sequencer owning the pc
module mini_ctrl_seq
    import mini_pkg::*;
#(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 16,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [1:0]         rf_raddr1,
    output logic [1:0]         rf_raddr2,
    output logic [1:0]         rf_waddr,
    output logic               rf_we,
    output logic [1:0]         alu_op,
    output logic [3:0]         imm,
    output logic               busy,
    output logic               halted,
    output logic [CNT_W-1:0]   instr_cnt
);
    state_t state, nstate;
    logic [PC_W-1:0] pc;
    logic [INSTR_W-1:0] instr;
    logic [1:0] d_raddr1, d_raddr2, d_waddr, d_alu_op;
    logic [3:0] d_imm;
    logic writes_rf, is_halt, active, idle_like, retire;

    mini_instr_decode u_dec (
        .instr     (instr[15:0]),
        .raddr1    (d_raddr1),
        .raddr2    (d_raddr2),
        .waddr     (d_waddr),
        .alu_op    (d_alu_op),
        .imm       (d_imm),
        .writes_rf (writes_rf),
        .is_halt   (is_halt)
    );

    always_comb begin
        nstate = state;
        case (state)
            S_IDLE, S_HALT: nstate = start ? S_FETCH : state;
            S_FETCH:        nstate = imem_ack ? S_DECODE : S_FETCH;
            S_DECODE:       nstate = S_EXEC;
            S_EXEC:         nstate = is_halt ? S_HALT : S_WB;
            S_WB:           nstate = S_FETCH;
            default:        nstate = S_IDLE;
        endcase
    end

    // Decode fields are only meaningful once an instruction has been latched
    assign active    = state == S_DECODE || state == S_EXEC || state == S_WB;
    assign idle_like = state == S_IDLE || state == S_HALT;
    assign retire    = state == S_WB || (state == S_EXEC && is_halt);
    assign imem_req  = state == S_FETCH;
    assign imem_addr = pc;
    assign rf_raddr1 = active ? d_raddr1 : '0;
    assign rf_raddr2 = active ? d_raddr2 : '0;
    assign rf_waddr  = active ? d_waddr : '0;
    assign alu_op    = active ? d_alu_op : '0;
    assign imm       = active ? d_imm : '0;
    assign rf_we     = state == S_WB && writes_rf;
    assign busy      = imem_req || active;
    assign halted    = state == S_HALT;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            pc        <= '0;
            instr     <= '0;
            instr_cnt <= '0;
        end else begin
            state <= nstate;
            if (idle_like && start) begin
                pc        <= '0;
                instr_cnt <= '0;
            end
            if (state == S_FETCH && imem_ack) instr <= imem_rdata;
            if (state == S_WB) pc <= pc + PC_W'(1);
            if (retire && instr_cnt != '1) instr_cnt <= instr_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_mini_ctrl_seq.sv
// tb_mini_ctrl_seq: directed bench driving imem handshakes and checking sequencer outputs
module tb_mini_ctrl_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack = 1'b0;
    logic [15:0] imem_rdata = 16'hFFFF;
    logic [1:0]  rf_raddr1, rf_raddr2, rf_waddr, alu_op;
    logic        rf_we, busy, halted;
    logic [3:0]  imm;
    logic [15:0] instr_cnt;
    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    mini_ctrl_seq dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .rf_raddr1  (rf_raddr1),
        .rf_raddr2  (rf_raddr2),
        .rf_waddr   (rf_waddr),
        .rf_we      (rf_we),
        .alu_op     (alu_op),
        .imm        (imm),
        .busy       (busy),
        .halted     (halted),
        .instr_cnt  (instr_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step;
        @(negedge clk);
    endtask

    // Entered and left at the negedge of a FETCH cycle
    task automatic run_instr(input logic [15:0] ins, input int waits, input logic [7:0] a,
                             input logic we, input logic [1:0] op, input logic [1:0] wa,
                             input logic [3:0] rs, input logic [3:0] im, input logic st);
        int c0;
        c0 = cyc;
        start = st;
        for (int i = 0; i < waits; i++) begin
            chk("wait_req", imem_req, 1);
            chk("wait_addr", imem_addr, a);
            chk("wait_nodec", {rf_we, rf_waddr, alu_op, imm}, 0);
            imem_ack = 1'b0;
            imem_rdata = 16'hFFFF;
            step;
        end
        chk("req", imem_req, 1);
        chk("addr", imem_addr, a);
        imem_ack = 1'b1;
        imem_rdata = ins;
        step;
        imem_ack = 1'b0;
        imem_rdata = 16'hFFFF;
        chk("dec_req", imem_req, 0);
        chk("dec_busy", busy, 1);
        chk("dec_op", alu_op, op);
        chk("dec_wa", rf_waddr, wa);
        chk("dec_rs", {rf_raddr1, rf_raddr2}, rs);
        chk("dec_we", rf_we, 0);
        step;
        chk("exe_we", rf_we, 0);
        step;
        chk("wb_we", rf_we, we);
        chk("wb_imm", imm, im);
        step;
        start = 1'b0;
        chk("period", cyc - c0, waits + 4);
    endtask

    task automatic do_start;
        start = 1'b1;
        step;
        start = 1'b0;
    endtask

    initial begin
        step;
        step;
        chk("rst_busy", busy, 0);
        chk("rst_halted", halted, 0);
        chk("rst_req", imem_req, 0);
        chk("rst_we", rf_we, 0);
        chk("rst_cnt", instr_cnt, 0);
        chk("rst_outs", {imem_addr, rf_raddr1, rf_raddr2, rf_waddr, alu_op, imm}, 0);
        rst = 1'b0;
        step;
        chk("idle_req", imem_req, 0);
        do_start;
        // R1 <= R0 + R1 with immediate ack, then SUB with three wait cycles
        run_instr(16'h4400, 0, 8'd0, 1, 2'b00, 2'd1, 4'b0001, 4'h0, 0);
        chk("add_pc", imem_addr, 1);
        chk("add_cnt", instr_cnt, 1);
        run_instr(16'hD500, 3, 8'd1, 1, 2'b01, 2'd3, 4'b0101, 4'h0, 0);
        chk("sub_pc", imem_addr, 2);
        chk("sub_cnt", instr_cnt, 2);
        // LDI, NOP, HALT from a fresh start
        rst = 1'b1;
        step;
        rst = 1'b0;
        do_start;
        run_instr(16'h8205, 0, 8'd0, 1, 2'b10, 2'd2, 4'b0000, 4'h5, 0);
        run_instr(16'h0300, 0, 8'd1, 0, 2'b11, 2'd0, 4'b0000, 4'h0, 0);
        chk("h_addr", imem_addr, 2);
        imem_ack = 1'b1;
        imem_rdata = 16'h03F0;
        step;
        imem_ack = 1'b0;
        imem_rdata = 16'hFFFF;
        chk("h_dec_halted", halted, 0);
        step;
        chk("h_exe_we", rf_we, 0);
        step;
        chk("h_halted", halted, 1);
        chk("h_busy", busy, 0);
        chk("h_pc", imem_addr, 2);
        chk("h_cnt", instr_cnt, 3);
        chk("h_we", rf_we, 0);
        chk("h_req", imem_req, 0);
        imem_ack = 1'b1;
        step;
        imem_ack = 1'b0;
        chk("h_stray_ack", {halted, busy}, 2'b10);
        chk("h_cnt_hold", instr_cnt, 3);
        // Restart from HALT, then hold start while busy
        do_start;
        chk("rs_addr", imem_addr, 0);
        chk("rs_cnt", instr_cnt, 0);
        chk("rs_state", {halted, busy, imem_req}, 3'b011);
        run_instr(16'h0300, 1, 8'd0, 0, 2'b11, 2'd0, 4'b0000, 4'h0, 1);
        run_instr(16'h0300, 0, 8'd1, 0, 2'b11, 2'd0, 4'b0000, 4'h0, 1);
        chk("sb_pc", imem_addr, 2);
        chk("sb_cnt", instr_cnt, 2);
        // Reset while a fetch is pending
        rst = 1'b1;
        step;
        rst = 1'b0;
        chk("rf_req", imem_req, 0);
        chk("rf_busy", busy, 0);
        chk("rf_we", rf_we, 0);
        chk("rf_cnt", instr_cnt, 0);
        chk("rf_pc", imem_addr, 0);
        // Reset during WB
        do_start;
        imem_ack = 1'b1;
        imem_rdata = 16'h8205;
        step;
        imem_ack = 1'b0;
        step;
        step;
        chk("rw_wb_we", rf_we, 1);
        rst = 1'b1;
        step;
        rst = 1'b0;
        chk("rw_we", rf_we, 0);
        chk("rw_state", {busy, imem_req, halted}, 0);
        step;
        chk("rw_idle_we", rf_we, 0);
        // Reset during EXEC: the interrupted write never issues
        do_start;
        imem_ack = 1'b1;
        imem_rdata = 16'h4400;
        step;
        imem_ack = 1'b0;
        step;
        rst = 1'b1;
        step;
        rst = 1'b0;
        chk("re_we", rf_we, 0);
        chk("re_busy", busy, 0);
        step;
        chk("re_we2", rf_we, 0);
        // 256 NOPs walk the pc through every address and wrap to 0
        do_start;
        for (int i = 0; i < 256; i++)
            run_instr(16'h0300, 0, 8'(i), 0, 2'b11, 2'd0, 4'b0000, 4'h0, 0);
        chk("wrap_addr", imem_addr, 0);
        chk("wrap_req", imem_req, 1);
        chk("wrap_cnt", instr_cnt, 256);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
